// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the register file: core writeback has priority, aux writes are
// buffered and drained into idle cycles, and a clear-all sequencer zeroes x1..x(2^AW-1).
module regfile_wr_arbiter #(
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 5,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_we,
  input  logic [AW-1:0] core_wa,
  input  logic [DW-1:0] core_wd,
  output logic          core_stall,
  input  logic          aux_valid,
  output logic          aux_ready,
  input  logic [AW-1:0] aux_wa,
  input  logic [DW-1:0] aux_wd,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          WE3,
  output logic [AW-1:0] A3,
  output logic [DW-1:0] WD3
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StClear = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [AW-1:0]         fwa_q [FIFO_DEPTH];
  logic [DW-1:0]         fwd_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fok_q;
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [PW:0]           cnt_q;

  logic arb_en, core_wr, fifo_empty, fifo_full, pop, push, clr_go;

  // IDLE and DONE both arbitrate normally; CLEAR owns the port.
  assign arb_en     = !reset && (state_q != StClear);
  assign core_wr    = arb_en && core_we && (core_wa != '0);
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign pop        = arb_en && !core_wr && !fifo_empty;
  assign aux_ready  = !reset && (state_q == StIdle) && !fifo_full;
  // x0 requests complete the handshake but are never queued.
  assign push       = aux_valid && aux_ready && (aux_wa != '0);
  assign clr_go     = !reset && (state_q == StIdle) && clr_start;

  assign core_stall = !reset && (state_q == StClear);
  assign clr_busy   = !reset && (state_q == StClear);
  assign clr_done   = !reset && (state_q == StDone);

  always_comb begin
    WE3 = 1'b0;
    A3  = '0;
    WD3 = '0;
    if (!reset) begin
      if (state_q == StClear) begin
        WE3 = 1'b1;
        A3  = idx_q;
      end else if (core_wr) begin
        WE3 = 1'b1;
        A3  = core_wa;
        WD3 = core_wd;
      end else if (pop && fok_q[rptr_q]) begin
        WE3 = 1'b1;
        A3  = fwa_q[rptr_q];
        WD3 = fwd_q[rptr_q];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle: begin
        if (clr_start) begin
          state_d = StClear;
          idx_d   = AW'(1);
        end
      end
      StClear: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == '1) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr_go) begin
      fok_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      // A core write supersedes any older queued write to the same register.
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        if (core_wr && (fwa_q[i] == core_wa)) fok_q[i] <= 1'b0;
      end
      if (push) begin
        fwa_q[wptr_q] <= aux_wa;
        fwd_q[wptr_q] <= aux_wd;
        fok_q[wptr_q] <= 1'b1;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
      cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Owns the single write port (WE3/A3/WD3) of regfile and shares it between the core writeback path and an auxiliary writer (multi-cycle unit or debug loader).
- Also sequences a "clear all registers" operation.
- Sits between the single-cycle datapath writeback mux and regfile. The core has absolute priority; aux writes are buffered and drained into idle write-port cycles.

Parameters:
- DW, 32, data width.
- AW, 5, register address width (2^AW registers; x0 is hard-zero).
- FIFO_DEPTH, 2, aux write buffer entries (power of two, >=2).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- core_we  in  1  core writeback enable.
- core_wa  in  AW  core destination register.
- core_wd  in  DW  core writeback data.
- core_stall  out  1  high while clear is in progress; core must hold its PC.
- aux_valid  in  1  aux write request.
- aux_ready  out  1  aux request accepted when aux_valid && aux_ready at posedge.
- aux_wa  in  AW  aux destination register.
- aux_wd  in  DW  aux write data.
- clr_start  in  1  start a clear of x1..x(2^AW-1); sampled only in IDLE.
- clr_busy  out  1  high in CLEAR state.
- clr_done  out  1  one-cycle pulse when the clear completes.
- WE3  out  1  to regfile write enable.
- A3  out  AW  to regfile write address.
- WD3  out  DW  to regfile write data.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, FIFO empty, clear index=0. While reset is high: WE3=0, A3=0, WD3=0, aux_ready=0, core_stall=0, clr_busy=0, clr_done=0.
- States: IDLE, CLEAR, DONE.
  - IDLE->CLEAR on clr_start.
  - CLEAR->DONE after writing index 2^AW-1.
  - DONE->IDLE unconditionally.
- Write-port mux is combinational from the current state and inputs; zero added latency for core writes.
- IDLE, core write (core_we=1 and core_wa!=0): WE3=1, A3=core_wa, WD3=core_wd. The FIFO does not drain this cycle.
- IDLE, core_we=1 with core_wa=0: treated as no core write. WE3 is not driven by the core, and the port is free for the FIFO.
- IDLE, port free and FIFO non-empty: WE3=1, A3/WD3 = FIFO head; pop at posedge.
- IDLE, port free and FIFO empty: WE3=0, A3=0, WD3=0.
- aux_ready = (state==IDLE) && FIFO not full && !reset. Push and pop in the same cycle are allowed, so a full FIFO that pops this cycle still reports aux_ready=0 (no lookahead).
- Aux request with aux_wa=0: accepted (handshake completes) and discarded, never queued.
- Ordering hazard: a core write to address A invalidates every FIFO entry with address A at that posedge (entries are dropped, not written). The core value is the newer one in program order. An aux request pushed in the same cycle to the same A is NOT invalidated, since it is newer than the core write.
- Invalid entries reaching the head are popped without asserting WE3; that cycle the port is idle.
- CLEAR entry (clr_start in IDLE at posedge N):
  - State becomes CLEAR, index=1, FIFO flushed.
  - The clr_start cycle itself still performs normal IDLE arbitration.
- In CLEAR:
  - WE3=1, A3=index, WD3=0.
  - core_stall=1 and clr_busy=1; core_we is ignored; aux_ready=0.
  - Index increments each cycle.
  - Register x1 is written in cycle N+1 and x31 in cycle N+31 (AW=5).
- DONE (cycle N+32): clr_done=1 and core_stall=0, with normal IDLE arbitration. This is the only cycle clr_done is high.
- clr_start while in CLEAR or DONE: ignored.
- Reset mid-clear: the clear aborts immediately, the following cycle is IDLE, and no clr_done pulse is produced.
- Counters and FIFO pointers wrap modulo size; the index never exceeds 2^AW-1.

Test Plan:
- Reset held 2 cycles, then released -> WE3=0, aux_ready=1, clr_busy=0; a regfile read of x5 after a prior core write of 5/0x12 still shows 0x12 (the arbiter does not clear on reset).
- Core writes x1=0x1, x2=0x2, x7=0x12 on consecutive cycles -> WE3=1 with the matching A3/WD3 in the same cycle; readback rd1(x2)=0x2, rd2(x7)=0x12.
- Aux pushes x3=0xAA, x4=0xBB while core_we=1 continuously -> aux_ready drops to 0 after 2 pushes; when core_we falls, x3 then x4 are written on the next 2 cycles in order.
- Aux queues x9=0x55, then core writes x9=0x77 before the drain -> the entry is dropped; final x9=0x77, and no WE3 with A3=9/WD3=0x55 ever appears.
- clr_start at cycle N with x1..x31 preloaded nonzero:
  - core_stall=1 for cycles N+1..N+31 and clr_done=1 only at N+32.
  - All of x1..x31 read 0 afterwards.
  - A core_we during the stall does not reach WE3.
- Reset asserted at clear index 10 -> next cycle state is IDLE, no clr_done pulse, x11..x31 retain their prior values; aux writes and core_wa=0 writes are then checked (x0 reads 0, the aux x0 request is accepted and not written).
